// File: rtl/dht11_leitor_if.sv
// Sensor-side bundle for dht11_leitor: start request, raw line, pad enable and results.
interface dht11_leitor_if;
    logic        iniciar;
    logic        dht_in;
    logic        dht_oe;
    logic [15:0] temp;
    logic [15:0] umidade;
    logic        pronto;
    logic        erro;
    logic        ocupado;

    modport master (
        output iniciar, dht_in,
        input  dht_oe, temp, umidade, pronto, erro, ocupado
    );

    modport slave (
        input  iniciar, dht_in,
        output dht_oe, temp, umidade, pronto, erro, ocupado
    );
endinterface

// File: rtl/dht11_leitor.sv
// DHT11 single-wire reader: start pulse, response handshake, 40-bit decode into {int,dec} words.
// Define TUSCA_DHT_CHECKSUM_EN to reject frames whose checksum byte does not match.
//
// state       | meaning
// OCIOSO      | idle, waiting for iniciar
// START_BAIXO | host holds the line low
// ESPERA_RESP | line released, waiting for sensor to pull low
// RESP_BAIXO  | sensor response low phase
// RESP_ALTO   | sensor response high phase
// BIT_BAIXO   | low preamble of a data bit
// BIT_ALTO    | high part of a data bit, length gives the value
// CHECA       | frame complete, validate and latch
module dht11_leitor #(
    parameter int CICLOS_US    = 50,
    parameter int T_START_US   = 18000,
    parameter int T_TIMEOUT_US = 200,
    parameter int T_LIMIAR_US  = 48
) (
    input  logic          clock,
    input  logic          reset,
    dht11_leitor_if.slave bus
);
    localparam int CW = $clog2(T_START_US * CICLOS_US) + 1;
    localparam logic [CW-1:0] START_FIM   = CW'(T_START_US * CICLOS_US - 1);
    localparam logic [CW-1:0] TIMEOUT_FIM = CW'(T_TIMEOUT_US * CICLOS_US - 1);
    localparam logic [CW-1:0] LIMIAR      = CW'(T_LIMIAR_US * CICLOS_US);

    typedef enum logic [2:0] {
        OCIOSO, START_BAIXO, ESPERA_RESP, RESP_BAIXO,
        RESP_ALTO, BIT_BAIXO, BIT_ALTO, CHECA
    } estado_t;

    estado_t        state_q, state_d;
    logic [1:0]     sync_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [5:0]     bit_cnt_q, bit_cnt_d;
    logic [39:0]    shift_q, shift_d;
    logic [15:0]    temp_q, temp_d;
    logic [15:0]    umid_q, umid_d;
    logic           pronto_q, pronto_d;
    logic           erro_q, erro_d;
    logic           s;
    logic           timeout;
    logic           frame_ok;

    assign s       = sync_q[1];
    assign timeout = (cnt_q == TIMEOUT_FIM);

`ifdef TUSCA_DHT_CHECKSUM_EN
    logic [7:0] soma;
    assign soma     = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];
    assign frame_ok = (soma == shift_q[7:0]);
`else
    logic unused_ck;
    assign unused_ck = ^shift_q[7:0];
    assign frame_ok  = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q    <= 2'b11;
            state_q   <= OCIOSO;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            temp_q    <= '0;
            umid_q    <= '0;
            pronto_q  <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], bus.dht_in};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            temp_q    <= temp_d;
            umid_q    <= umid_d;
            pronto_q  <= pronto_d;
            erro_q    <= erro_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        temp_d    = temp_q;
        umid_d    = umid_q;
        pronto_d  = 1'b0;
        erro_d    = 1'b0;

        case (state_q)
            OCIOSO: begin
                if (bus.iniciar) begin
                    state_d   = START_BAIXO;
                    bit_cnt_d = '0;
                end
            end
            START_BAIXO: if (cnt_q == START_FIM) state_d = ESPERA_RESP;
            ESPERA_RESP, RESP_BAIXO, RESP_ALTO, BIT_BAIXO, BIT_ALTO: begin
                // Timeout wins over an edge arriving on the same cycle.
                if (timeout) begin
                    erro_d  = 1'b1;
                    state_d = OCIOSO;
                end else begin
                    case (state_q)
                        ESPERA_RESP: if (!s) state_d = RESP_BAIXO;
                        RESP_BAIXO:  if (s)  state_d = RESP_ALTO;
                        RESP_ALTO:   if (!s) state_d = BIT_BAIXO;
                        BIT_BAIXO:   if (s)  state_d = BIT_ALTO;
                        default: begin
                            if (!s) begin
                                shift_d = {shift_q[38:0], (cnt_q > LIMIAR)};
                                if (bit_cnt_q == 6'd39) begin
                                    state_d = CHECA;
                                end else begin
                                    bit_cnt_d = bit_cnt_q + 6'd1;
                                    state_d   = BIT_BAIXO;
                                end
                            end
                        end
                    endcase
                end
            end
            CHECA: begin
                state_d = OCIOSO;
                if (frame_ok) begin
                    umid_d   = shift_q[39:24];
                    temp_d   = shift_q[23:8];
                    pronto_d = 1'b1;
                end else begin
                    erro_d = 1'b1;
                end
            end
            default: state_d = OCIOSO;
        endcase

        cnt_d = (state_d != state_q || state_q == OCIOSO) ? '0 : cnt_q + 1'b1;
    end

    assign bus.dht_oe  = (state_q == START_BAIXO);
    assign bus.ocupado = (state_q != OCIOSO);
    assign bus.temp    = temp_q;
    assign bus.umidade = umid_q;
    assign bus.pronto  = pronto_q;
    assign bus.erro    = erro_q;
endmodule

// File: doc/dht11_leitor.md
# dht11_leitor

Upstream sensor stage for `tusca_fd`: drives the DHT11 single-wire protocol, decodes the 40-bit frame and presents `temp` and `umidade` in the `{integer byte, decimal byte}` format that `tusca_fd` consumes. A measurement starts on a one-cycle `iniciar` pulse. Registered outputs change only on a successfully decoded frame. `pronto` or `erro` reports the outcome of each transaction.

## Interface
- `CICLOS_US`, 50: clock cycles per microsecond.
- `T_START_US`, 18000: duration of the host start low pulse.
- `T_TIMEOUT_US`, 200: maximum time allowed in any wait-for-edge state.
- `T_LIMIAR_US`, 48: bit-high duration threshold; longer than this decodes as 1, otherwise 0.

Ports:
- `clock`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `iniciar`  in  1  start request; honoured only when `ocupado`=0.
- `dht_in`  in  1  raw line level; asynchronous to `clock`.
- `dht_oe`  out  1  1 = pad drives line low; 0 = released (pull-up).
- `temp`  out  16  `{int, dec}` temperature from the last valid frame.
- `umidade`  out  16  `{int, dec}` humidity from the last valid frame.
- `pronto`  out  1  one-cycle pulse: valid frame latched.
- `erro`  out  1  one-cycle pulse: timeout or checksum failure.
- `ocupado`  out  1  high from accepted `iniciar` until `pronto` or `erro`.

## Operation
- `dht_in` passes through a 2-flop synchronizer. All edge decisions use the synchronized level `s`.
- A single duration counter is used, width `$clog2(T_START_US*CICLOS_US)+1`. It is cleared on every state change.
- FSM states and transitions:
  - OCIOSO: `iniciar` → START_BAIXO.
  - START_BAIXO: `dht_oe`=1 for T_START_US*CICLOS_US cycles → ESPERA_RESP.
  - ESPERA_RESP: `dht_oe`=0; `s`=0 → RESP_BAIXO.
  - RESP_BAIXO: `s`=1 → RESP_ALTO.
  - RESP_ALTO: `s`=0 → BIT_BAIXO.
  - BIT_BAIXO: `s`=1 → BIT_ALTO.
  - BIT_ALTO: `s`=0 → shift in the bit (counter > T_LIMIAR_US*CICLOS_US ⇒ 1). Bit index < 39 → BIT_BAIXO; bit index = 39 → CHECA.
  - CHECA: frame check (see below), then → OCIOSO.
- Timeout: in ESPERA_RESP, RESP_*, or BIT_*, a counter reaching T_TIMEOUT_US*CICLOS_US → erro pulse, → OCIOSO.
- Frame format: MSB first; bytes are H_int, H_dec, T_int, T_dec, CK.
- Frame check: valid when (H_int+H_dec+T_int+T_dec) mod 256 == CK.
  - Valid: `umidade`←{H_int,H_dec}, `temp`←{T_int,T_dec}, `pronto`=1.
  - Invalid: `erro`=1, outputs hold their previous values.
- `iniciar` while `ocupado`=1 is ignored; it is neither queued nor restarts the transaction.
- `reset` in any state → OCIOSO next edge, `dht_oe`=0, bit count cleared.

## Timing
- Reset values: `temp`=0, `umidade`=0, `dht_oe`=0, `pronto`=0, `erro`=0, `ocupado`=0.
- `ocupado` and `dht_oe` rise on the edge after `iniciar` is sampled.
- `dht_oe` falls exactly T_START_US*CICLOS_US cycles later.
- Synchronizer latency is 2 cycles; bit durations are measured in `s` and are unaffected by it.
- `temp`, `umidade` and `pronto` update on the same edge: the edge leaving CHECA, one cycle after the 40th bit is shifted in. `ocupado` falls on that same edge.
- `pronto` and `erro` are each high for exactly one cycle and are never high together.
- Timeout `erro` is asserted on the edge where the counter hits its limit.

## Configuration
- `TUSCA_DHT_CHECKSUM_EN` defined: checksum verified as above.
- Not defined: CK is shifted in but ignored. Every complete 40-bit frame latches and pulses `pronto`; `erro` arises only from timeouts.

## Test plan
- Setup: sensor model, CICLOS_US=1, T_START_US=100.
- Valid frame: frame 54,2,18,5,CK=79 → `umidade`=16'h3602, `temp`=16'h1205, one-cycle `pronto`, `ocupado` low after it.
- Bad checksum: frame 54,2,27,2,CK=0 → one-cycle `erro`, `temp`/`umidade` hold the previous 16'h1205/16'h3602. Without the macro → `pronto`, `temp`=16'h1B02.
- No response: `dht_in` held 1 after start → `erro` exactly T_TIMEOUT_US cycles after `dht_oe` falls; `dht_oe`=0 throughout the wait.
- Start length: `iniciar` pulse → `dht_oe`=1 for exactly 100 cycles. Second `iniciar` mid-transaction → no restart, no extra start pulse.
- Mid-transaction reset: `reset` asserted at bit 20 → next edge all outputs at reset values. New `iniciar` then frame 32,5 temp → `temp`=16'h2005.
